// File: rtl/pc_sequencer_pkg.sv
// Shared CPU constants: fetch address map, exception vector and the
// fetch sequencer state encoding.
package pc_sequencer_pkg;

   localparam logic [31:0] RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
   localparam logic [31:0] IMEM_LO    = 32'h0000_3000;
   localparam logic [31:0] IMEM_HI    = 32'h0000_6FFC;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } pc_state_e;

endpackage

// File: rtl/pc_sequencer_range_chk.sv
// Fetch address fault detect: misaligned or outside instruction memory,
// reported only while the fetch address is live.
module pc_range_chk
   import pc_sequencer_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic        pc_valid_i,
   output logic        adel_if_o
);

   logic misaligned;
   logic out_of_range;

   assign misaligned   = (pc_i[1:0] != 2'b00);
   assign out_of_range = (pc_i < IMEM_LO) || (pc_i > IMEM_HI);
   assign adel_if_o    = pc_valid_i && (misaligned || out_of_range);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: boot cycle, sequential fetch, delayed branch redirect
// (held across stalls), exception entry and exception return.
module pc_sequencer
   import pc_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redir_valid,
   input  logic [31:0] redir_target,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] pc,
   output logic        pc_valid,
   output logic        redir_pend,
   output logic        adel_if
);

   pc_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] tgt_q, tgt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
      end
   end

   // Exception entry/return override everything, including a pending redirect.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      if (exc_req) begin
         pc_d    = EXC_VECTOR;
         state_d = RUN;
      end else if (eret_req) begin
         pc_d    = epc;
         state_d = RUN;
      end else begin
         case (state_q)
            BOOT: state_d = RUN;
            PEND: begin
               if (!stall) begin
                  pc_d    = tgt_q;
                  state_d = RUN;
               end
            end
            default: begin
               if (redir_valid) begin
                  if (stall) begin
                     tgt_d   = redir_target;
                     state_d = PEND;
                  end else begin
                     pc_d = redir_target;
                  end
               end else if (!stall) begin
                  pc_d = pc_q + 32'd4;
               end
            end
         endcase
      end
   end

   assign pc         = pc_q;
   assign pc_valid   = (state_q != BOOT);
   assign redir_pend = (state_q == PEND);

   pc_range_chk u_range_chk (
      .pc_i       (pc_q),
      .pc_valid_i (pc_valid),
      .adel_if_o  (adel_if)
   );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random
// stimulus compared against a behavioural fetch-address model.
module tb_pc_sequencer;
   import pc_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        redir_valid = 1'b0;
   logic [31:0] redir_target = '0;
   logic        exc_req = 1'b0;
   logic        eret_req = 1'b0;
   logic [31:0] epc = '0;
   logic [31:0] pc;
   logic        pc_valid, redir_pend, adel_if;

   int tests = 0;
   int fails = 0;

   // Model state: booting flag, pending redirect flag/target, fetch address
   bit          m_boot;
   bit          m_pend;
   logic [31:0] m_pc;
   logic [31:0] m_tgt;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .redir_valid  (redir_valid),
      .redir_target (redir_target),
      .exc_req      (exc_req),
      .eret_req     (eret_req),
      .epc          (epc),
      .pc           (pc),
      .pc_valid     (pc_valid),
      .redir_pend   (redir_pend),
      .adel_if      (adel_if)
   );

   function automatic bit m_adel();
      if (m_boot) return 1'b0;
      return (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc > 32'h6FFC);
   endfunction

   task automatic idle_inputs();
      stall = 0; redir_valid = 0; redir_target = '0;
      exc_req = 0; eret_req = 0; epc = '0;
   endtask

   task automatic model_reset();
      m_boot = 1; m_pend = 0; m_pc = 32'h3000; m_tgt = '0;
   endtask

   // Hold reset across one edge, release it just after the edge.
   task automatic pulse_reset();
      reset = 1;
      model_reset();
      @(posedge clk); #1;
      reset = 0;
      #1;
   endtask

   // Advance one clock and apply the fetch rules to the model.
   task automatic tick();
      @(posedge clk);
      if (exc_req) begin
         m_pc = 32'h4180; m_boot = 0; m_pend = 0;
      end else if (eret_req) begin
         m_pc = epc; m_boot = 0; m_pend = 0;
      end else if (m_boot) begin
         m_boot = 0;
      end else if (m_pend) begin
         if (!stall) begin m_pc = m_tgt; m_pend = 0; end
      end else if (redir_valid) begin
         if (stall) begin m_tgt = redir_target; m_pend = 1; end
         else m_pc = redir_target;
      end else if (!stall) begin
         m_pc = m_pc + 4;
      end
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      pulse_reset();
      tests++; if (pc !== 32'h3000) begin fails++; $display("FAIL reset_pc: got %h want %h", pc, 32'h3000); end
      tests++; if (pc_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", pc_valid); end
      tests++; if (redir_pend !== 1'b0) begin fails++; $display("FAIL reset_pend: got %b want 0", redir_pend); end
      tests++; if (adel_if !== 1'b0) begin fails++; $display("FAIL reset_adel: got %b want 0", adel_if); end
   endtask

   task automatic test_sequential();
      logic [31:0] exp [5];
      exp = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010};
      for (int i = 0; i < 5; i++) begin
         tick();
         tests++; if (pc !== exp[i]) begin fails++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, exp[i]); end
         tests++; if (pc_valid !== 1'b1) begin fails++; $display("FAIL seq_valid[%0d]: got %b want 1", i, pc_valid); end
      end
   endtask

   task automatic test_redirect();
      redir_valid = 1; redir_target = 32'h3400; stall = 0;
      tick();
      idle_inputs();
      tests++; if (pc !== 32'h3400) begin fails++; $display("FAIL redir_pc: got %h want %h", pc, 32'h3400); end
      tests++; if (redir_pend !== 1'b0) begin fails++; $display("FAIL redir_pend: got %b want 0", redir_pend); end
   endtask

   task automatic test_pend();
      eret_req = 1; epc = 32'h3010;
      tick();
      idle_inputs();
      redir_valid = 1; redir_target = 32'h3400; stall = 1;
      tick();
      tests++; if (pc !== 32'h3010) begin fails++; $display("FAIL pend_hold1: got %h want %h", pc, 32'h3010); end
      tests++; if (redir_pend !== 1'b1) begin fails++; $display("FAIL pend_flag1: got %b want 1", redir_pend); end
      // A second redirect while pending must be ignored
      redir_target = 32'h5000;
      tick();
      tests++; if (pc !== 32'h3010) begin fails++; $display("FAIL pend_hold2: got %h want %h", pc, 32'h3010); end
      tests++; if (redir_pend !== 1'b1) begin fails++; $display("FAIL pend_flag2: got %b want 1", redir_pend); end
      idle_inputs();
      tick();
      tests++; if (pc !== 32'h3400) begin fails++; $display("FAIL pend_load: got %h want %h", pc, 32'h3400); end
      tests++; if (redir_pend !== 1'b0) begin fails++; $display("FAIL pend_clear: got %b want 0", redir_pend); end
   endtask

   task automatic test_exc_in_pend();
      eret_req = 1; epc = 32'h3010;
      tick();
      idle_inputs();
      redir_valid = 1; redir_target = 32'h3400; stall = 1;
      tick();
      redir_valid = 0; exc_req = 1;
      tick();
      exc_req = 0;
      tests++; if (pc !== 32'h4180) begin fails++; $display("FAIL exc_pc: got %h want %h", pc, 32'h4180); end
      tests++; if (redir_pend !== 1'b0) begin fails++; $display("FAIL exc_pend: got %b want 0", redir_pend); end
      stall = 0;
      tick();
      tests++; if (pc !== 32'h4184) begin fails++; $display("FAIL exc_no_tgt: got %h want %h", pc, 32'h4184); end
   endtask

   task automatic test_eret();
      eret_req = 1; epc = 32'h3122;
      tick();
      idle_inputs();
      tests++; if (pc !== 32'h3122) begin fails++; $display("FAIL eret_pc: got %h want %h", pc, 32'h3122); end
      tests++; if (adel_if !== 1'b1) begin fails++; $display("FAIL eret_adel: got %b want 1", adel_if); end
      exc_req = 1; eret_req = 1; epc = 32'h3500;
      tick();
      idle_inputs();
      tests++; if (pc !== 32'h4180) begin fails++; $display("FAIL exc_over_eret: got %h want %h", pc, 32'h4180); end
      tests++; if (adel_if !== 1'b0) begin fails++; $display("FAIL vec_adel: got %b want 0", adel_if); end
   endtask

   task automatic test_boundary();
      eret_req = 1; epc = 32'h6FFC;
      tick();
      idle_inputs();
      tests++; if (adel_if !== 1'b0) begin fails++; $display("FAIL hi_edge_adel: got %b want 0", adel_if); end
      tick();
      tests++; if (pc !== 32'h7000) begin fails++; $display("FAIL past_hi_pc: got %h want %h", pc, 32'h7000); end
      tests++; if (adel_if !== 1'b1) begin fails++; $display("FAIL past_hi_adel: got %b want 1", adel_if); end
      eret_req = 1; epc = 32'hFFFF_FFFC;
      tick();
      idle_inputs();
      tick();
      tests++; if (pc !== 32'h0) begin fails++; $display("FAIL wrap_pc: got %h want %h", pc, 32'h0); end
      tests++; if (adel_if !== 1'b1) begin fails++; $display("FAIL wrap_adel: got %b want 1", adel_if); end
   endtask

   task automatic test_async_reset();
      eret_req = 1; epc = 32'h3010;
      tick();
      idle_inputs();
      redir_valid = 1; redir_target = 32'h3400; stall = 1;
      tick();
      idle_inputs();
      #3 reset = 1;
      model_reset();
      #1;
      tests++; if (pc !== 32'h3000) begin fails++; $display("FAIL async_pc: got %h want %h", pc, 32'h3000); end
      tests++; if (pc_valid !== 1'b0) begin fails++; $display("FAIL async_valid: got %b want 0", pc_valid); end
      tests++; if (redir_pend !== 1'b0) begin fails++; $display("FAIL async_pend: got %b want 0", redir_pend); end
      @(posedge clk); #1;
      reset = 0;
      tick();
      tick();
      tests++; if (pc !== 32'h3004) begin fails++; $display("FAIL post_reset_pc: got %h want %h", pc, 32'h3004); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 79) == 0) pulse_reset();
         stall        = ($urandom_range(0, 2) == 0);
         redir_valid  = ($urandom_range(0, 3) == 0);
         redir_target = ($urandom_range(0, 3) != 0) ? 32'h3000 + ($urandom_range(0, 4095) << 2) : $urandom();
         exc_req      = ($urandom_range(0, 19) == 0);
         eret_req     = ($urandom_range(0, 19) == 0);
         epc          = ($urandom_range(0, 3) != 0) ? 32'h3000 + ($urandom_range(0, 4095) << 2) : $urandom();
         tick();
         tests++; if (pc !== m_pc) begin fails++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc, m_pc); end
         tests++; if (pc_valid !== !m_boot) begin fails++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, pc_valid, !m_boot); end
         tests++; if (redir_pend !== m_pend) begin fails++; $display("FAIL rnd_pend[%0d]: got %b want %b", i, redir_pend, m_pend); end
         tests++; if (adel_if !== m_adel()) begin fails++; $display("FAIL rnd_adel[%0d]: got %b want %b", i, adel_if, m_adel()); end
      end
      idle_inputs();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_sequential();
      test_redirect();
      test_pend();
      test_exc_in_pend();
      test_eret();
      test_boundary();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
